// File: rtl/nonce_collector.sv
// nonce_collector: gathers golden nonces from SLAVES miner cores, queues them
// in a small FIFO and hands them one at a time to a serial transmitter.
//
// Ports
//   uart_clk      single clock, rising edge
//   reset         synchronous, active-high
//   new_nonces    one-cycle valid pulse per slave
//   slave_nonces  32-bit nonce of slave i on bits [i*32+31:i*32]
//   serial_busy   transmitter busy flag
//   serial_send   one-cycle send strobe (registered)
//   golden_nonce  word being transmitted, changes only on a pop
//   fifo_count    FIFO occupancy, 0..2^DEPTH_BITS
//   overflow      sticky, set when a pending nonce is overwritten
module nonce_collector #(
    parameter int unsigned SLAVES     = 2,
    parameter int unsigned DEPTH_BITS = 3
) (
    input  logic                  uart_clk,
    input  logic                  reset,
    input  logic [SLAVES-1:0]     new_nonces,
    input  logic [SLAVES*32-1:0]  slave_nonces,
    input  logic                  serial_busy,
    output logic                  serial_send,
    output logic [31:0]           golden_nonce,
    output logic [DEPTH_BITS:0]   fifo_count,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam int unsigned IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int unsigned TO_W  = 4;

    localparam logic [DEPTH_BITS:0]   FULL_COUNT   = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   CNT_ONE      = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE      = DEPTH_BITS'(1);
    localparam logic [TO_W-1:0]       TIMEOUT_LAST = TO_W'(15);
    localparam logic [TO_W-1:0]       TO_ONE       = TO_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

    logic [SLAVES-1:0]     pend_flag;
    logic [31:0]           pend_val [SLAVES];
    logic [IDX_W-1:0]      rr_last;
    logic [31:0]           fifo_mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    tx_state_t             state;
    logic [TO_W-1:0]       timeout_cnt;

    logic                  fifo_full_c;
    logic                  pop_c;
    logic                  grant_valid_c;
    logic [IDX_W-1:0]      grant_idx_c;
    logic [IDX_W-1:0]      cand_c;

    assign fifo_full_c = (fifo_count == FULL_COUNT);
    assign pop_c       = (state == IDLE) && (fifo_count != '0) && !serial_busy;

    // Round-robin grant: first set flag searching upward from rr_last+1.
    always_comb begin
        grant_valid_c = 1'b0;
        grant_idx_c   = '0;
        cand_c        = '0;
        for (int unsigned k = 1; k <= SLAVES; k++) begin
            cand_c = IDX_W'((32'(rr_last) + k) % SLAVES);
            if (!grant_valid_c && !fifo_full_c && pend_flag[cand_c]) begin
                grant_valid_c = 1'b1;
                grant_idx_c   = cand_c;
            end
        end
    end

    // Storage without reset: pending values and FIFO payload.
    always_ff @(posedge uart_clk) begin
        if (!reset) begin
            if (grant_valid_c) begin
                fifo_mem[wr_ptr] <= pend_val[grant_idx_c];
            end
            for (int i = 0; i < SLAVES; i++) begin
                if (new_nonces[i]) begin
                    pend_val[i] <= slave_nonces[i*32 +: 32];
                end
            end
        end
    end

    // Pending flags, arbitration pointer, FIFO pointers and occupancy.
    always_ff @(posedge uart_clk) begin
        if (reset) begin
            pend_flag  <= '0;
            rr_last    <= IDX_W'(SLAVES - 1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (grant_valid_c) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                rr_last <= grant_idx_c;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({grant_valid_c, pop_c})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
            // A fresh capture beats the clear from a grant on the same edge.
            for (int i = 0; i < SLAVES; i++) begin
                if (new_nonces[i]) begin
                    pend_flag[i] <= 1'b1;
                    if (pend_flag[i] && !(grant_valid_c && grant_idx_c == IDX_W'(i))) begin
                        overflow <= 1'b1;
                    end
                end else if (grant_valid_c && grant_idx_c == IDX_W'(i)) begin
                    pend_flag[i] <= 1'b0;
                end
            end
        end
    end

    // Transmit handshake; a transmitter that never raises busy is released
    // after 16 quiet cycles so the queue cannot stall.
    always_ff @(posedge uart_clk) begin
        if (reset) begin
            state        <= IDLE;
            serial_send  <= 1'b0;
            golden_nonce <= '0;
            timeout_cnt  <= '0;
        end else begin
            serial_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        golden_nonce <= fifo_mem[rd_ptr];
                        serial_send  <= 1'b1;
                        timeout_cnt  <= '0;
                        state        <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (serial_busy) begin
                        state <= WAIT_DONE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (!serial_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/nonce_collector.md
NONCE_COLLECTOR -- requirements
Module: nonce_collector

Interface
REQ-001 The block SHALL have parameter SLAVES, default 2, giving the number of miner cores feeding the block (1..8).
REQ-002 The block SHALL have parameter DEPTH_BITS, default 3, giving the log2 of the FIFO depth (8 entries).
REQ-003 The block SHALL have port uart_clk  input  1  single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port new_nonces  input  SLAVES  one-cycle pulse per slave, already synchronised to uart_clk.
REQ-006 The block SHALL have port slave_nonces  input  SLAVES*32  golden nonce of slave i on bits [i*32+31:i*32], valid when new_nonces[i]=1.
REQ-007 The block SHALL have port serial_busy  input  1  serial transmitter busy flag.
REQ-008 The block SHALL have port serial_send  output  1  one-cycle send strobe to the serial transmitter.
REQ-009 The block SHALL have port golden_nonce  output  32  word to transmit, stable from serial_send until serial_busy falls.
REQ-010 The block SHALL have port fifo_count  output  DEPTH_BITS+1  current FIFO occupancy.
REQ-011 The block SHALL have port overflow  output  1  sticky flag, set when any nonce is lost.

Function
REQ-012 Capture: on an edge with new_nonces[i]=1, the block SHALL store slave_nonces[i] in pending register i and set pending flag i.
REQ-013 Capture and clear of the same slave on the same edge: capture SHALL win, the new value is stored and the flag stays set.
REQ-014 Lost nonce: a pulse on slave i while flag i is set and slave i is not granted that edge SHALL overwrite the pending value and set overflow.
REQ-015 Arbitration: each edge, if the FIFO is not full, the block SHALL grant one set pending flag using round-robin, searching upward from (last granted index + 1) mod SLAVES.
REQ-016 On a grant, the block SHALL write the pending value to the FIFO and clear the flag; if the FIFO is full, no grant occurs and pending registers hold.
REQ-017 FIFO: the FIFO SHALL have 2^DEPTH_BITS entries, circular read and write pointers that wrap modulo depth, and first-in first-out order.
REQ-018 fifo_count SHALL range 0..2^DEPTH_BITS; a write and a read on the same edge SHALL leave the count unchanged.
REQ-019 Transmit FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE: if fifo_count>0 and serial_busy=0, the FSM SHALL pop the head into golden_nonce, assert serial_send for exactly the following cycle, and go to WAIT_BUSY.
REQ-021 WAIT_BUSY: on serial_busy=1 the FSM SHALL go to WAIT_DONE; if serial_busy stays 0 for 16 cycles, it SHALL go to IDLE (word treated as sent).
REQ-022 WAIT_DONE: on serial_busy=0 the FSM SHALL go to IDLE.
REQ-023 golden_nonce SHALL change only on a pop.
REQ-024 Latency: a pulse sampled at edge k with the FIFO empty, FSM in IDLE and no contention SHALL produce serial_send=1 in the cycle following edge k+2.
REQ-025 Throughput: the block SHALL sustain one FIFO write per cycle, and at most one pop per transmitter cycle.

Reset
REQ-026 reset=1 at an edge SHALL clear all pending flags, the FIFO pointers and fifo_count, overflow, and serial_send, set the FSM to IDLE and the round-robin pointer to SLAVES-1 (so slave 0 has first priority), and set golden_nonce to 0.
REQ-027 Reset mid-transmission SHALL discard all queued and pending nonces; no serial_send SHALL occur while reset=1.
REQ-028 Pulses on new_nonces coincident with reset SHALL be ignored.

Verification
REQ-029 Single nonce: pulse new_nonces[0] with value 0x12345678, busy modelled as 1 for 10 cycles after send -> serial_send 3 cycles later, golden_nonce=0x12345678, fifo_count returns to 0.
REQ-030 Simultaneous: pulse slaves 0 and 1 together with values 0xA0000001 and 0xB0000002 -> both transmitted in order A then B, overflow=0.
REQ-031 Fairness: hold serial_busy=1, pulse slaves 0 and 1 every cycle for 20 cycles -> FIFO fills to 8 with entries alternating between slaves, overflow=1, and nothing is sent until busy falls.
REQ-032 Full FIFO: fill 8 entries, pulse slave 1 once -> value held in pending; after one pop the value enters the FIFO; overflow stays 0.
REQ-033 Busy timeout: FIFO holds 1 entry and serial_busy is never asserted -> serial_send pulses, FSM returns to IDLE after 16 cycles, and the next entry is sent.
REQ-034 Reset mid-run: reset asserted with 5 entries queued during WAIT_DONE -> fifo_count=0, overflow=0 and serial_send=0 the next cycle, and no stale word is sent after release.
